// File: rtl/wb_test_slave.sv
// wb_test_slave: Wishbone classic responder, RAM-backed, fixed wait states,
// ERR on out-of-range addresses, RTY on non-classic cycle types.
module wb_test_slave #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        CYC,
    input  logic        STB,
    input  logic        WE,
    input  logic [31:0] ADR,
    input  logic [31:0] DAT_I,
    input  logic [2:0]  CTI_I,
    output logic [31:0] DAT_O,
    output logic        ACK,
    output logic        ERR,
    output logic        RTY
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, TERM} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] adr_q, adr_d, dat_q, dat_d, dat_o_q, dat_o_d;
    logic [2:0]  cti_q, cti_d;
    logic        we_q, we_d, ack_q, ack_d, err_q, err_d, rty_q, rty_d;
    logic [31:0] mem [DEPTH];

    logic          idle, req, fire, is_err, is_rty, wr_en, cur_we;
    logic [31:0]   cur_adr, cur_dat;
    logic [2:0]    cur_cti;
    logic [AW-1:0] idx;

    always_comb begin
        idle    = state_q == IDLE;
        req     = idle && CYC && STB;
        // With zero wait states the decision is made from the live bus on the request edge
        cur_adr = idle ? ADR : adr_q;
        cur_dat = idle ? DAT_I : dat_q;
        cur_we  = idle ? WE : we_q;
        cur_cti = idle ? CTI_I : cti_q;
        idx     = cur_adr[AW-1:0];
        fire    = (req && WAIT_CYCLES == 0) || (state_q == WAIT && CYC && cnt_q == 4'd1);
        is_err  = cur_adr >= 32'(DEPTH);
        is_rty  = !is_err && cur_cti != 3'b000;
        ack_d   = fire && !is_err && !is_rty;
        err_d   = fire && is_err;
        rty_d   = fire && is_rty;
        wr_en   = ack_d && cur_we;
        dat_o_d = (ack_d && !cur_we) ? mem[idx] : '0;
        adr_d   = req ? ADR : adr_q;
        dat_d   = req ? DAT_I : dat_q;
        we_d    = req ? WE : we_q;
        cti_d   = req ? CTI_I : cti_q;
        cnt_d   = req ? 4'(WAIT_CYCLES) : (state_q == WAIT) ? cnt_q - 4'd1 : '0;
        state_d = fire ? TERM : req ? WAIT : (state_q == WAIT && CYC) ? WAIT : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            we_q    <= 1'b0;
            cti_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rty_q   <= 1'b0;
            dat_o_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            we_q    <= we_d;
            cti_q   <= cti_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rty_q   <= rty_d;
            dat_o_q <= dat_o_d;
        end
    end

    // Memory contents survive rst; only the ACK edge of a write commits
    always_ff @(posedge clk) begin
        if (!rst && wr_en) mem[idx] <= cur_dat;
    end

    assign ACK   = ack_q;
    assign ERR   = err_q;
    assign RTY   = rty_q;
    assign DAT_O = dat_o_q;
endmodule

// File: tb/tb_wb_test_slave.sv
// tb_wb_test_slave: vector table plus scoreboard for two instances,
// one with two wait states and one with none.
module tb_wb_test_slave;
    logic        clk = 0, rst = 1, sel = 0;
    logic        cyc = 0, stb = 0, we_i = 0;
    logic [31:0] adr_i = 0, dat_i = 0;
    logic [2:0]  cti_i = 0;
    logic        cyc0, cyc2;
    logic [31:0] dat_o0, dat_o2;
    logic        ack0, err0, rty0, ack2, err2, rty2;
    int          n_cmp = 0, n_err = 0;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [2:0]  cti;
        int          kind;
        logic [31:0] rdat;
    } vec_t;

    typedef struct {
        int          kind;
        logic [31:0] dat;
        int          cyc;
    } exp_t;

    vec_t        tv[$];
    exp_t        sb[$];
    logic [31:0] model [32];

    assign cyc2 = cyc & ~sel;
    assign cyc0 = cyc & sel;

    always #5 clk = ~clk;

    wb_test_slave #(.DEPTH(256), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .CYC(cyc2), .STB(stb), .WE(we_i), .ADR(adr_i),
        .DAT_I(dat_i), .CTI_I(cti_i), .DAT_O(dat_o2), .ACK(ack2), .ERR(err2), .RTY(rty2));

    wb_test_slave #(.DEPTH(256), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .CYC(cyc0), .STB(stb), .WE(we_i), .ADR(adr_i),
        .DAT_I(dat_i), .CTI_I(cti_i), .DAT_O(dat_o0), .ACK(ack0), .ERR(err0), .RTY(rty0));

    function automatic logic [2:0] enc(input int kind);
        return kind == 1 ? 3'b100 : kind == 2 ? 3'b010 : kind == 3 ? 3'b001 : 3'b000;
    endfunction

    task automatic xact(input logic s, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [2:0] cti, input int abort_at, input int rst_at,
                        input int kind, input logic [31:0] rdat, input string nm);
        int          w;
        logic [2:0]  t;
        logic [31:0] d;
        exp_t        x;
        w = s ? 0 : 2;
        @(negedge clk);
        sel = s; cyc = 1; stb = 1; we_i = we; adr_i = adr; dat_i = dat; cti_i = cti;
        if (kind != 0) sb.push_back('{kind, rdat, w + 1});
        for (int k = 1; k <= w + 3; k++) begin
            @(posedge clk);
            #1;
            rst = 1'b0;
            if (k == abort_at) cyc = 0;
            if (k == rst_at) begin rst = 1'b1; cyc = 0; stb = 0; end
            if (k == w + 2) begin cyc = 0; stb = 0; end
            @(negedge clk);
            t = s ? {ack0, err0, rty0} : {ack2, err2, rty2};
            d = s ? dat_o0 : dat_o2;
            n_cmp++;
            if ($countones(t) > 1) begin
                n_err++;
                $display("FAIL %s excl c%0d: ack/err/rty=%b required at most one high", nm, k, t);
            end
            if (t != 3'b000) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL %s unexpected c%0d: ack/err/rty=%b required 000", nm, k, t);
                end else begin
                    x = sb.pop_front();
                    if (t != enc(x.kind) || k != x.cyc || d != x.dat) begin
                        n_err++;
                        $display("FAIL %s term: got %b c%0d dat=%h required %b c%0d dat=%h",
                                 nm, t, k, d, enc(x.kind), x.cyc, x.dat);
                    end
                end
            end else begin
                n_cmp++;
                if (d != 32'h0) begin
                    n_err++;
                    $display("FAIL %s idle dat c%0d: got %h required 00000000", nm, k, d);
                end
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL %s timeout: termination missing, required kind %0d in c%0d", nm, sb[0].kind, sb[0].cyc);
            sb.delete();
        end
    endtask

    initial begin
        tv.push_back('{1'b1, 32'd5,          32'h0000_0005, 3'b000, 1, 32'h0});
        tv.push_back('{1'b0, 32'd5,          32'h0,         3'b000, 1, 32'h0000_0005});
        tv.push_back('{1'b0, 32'd256,        32'h0,         3'b000, 2, 32'h0});
        tv.push_back('{1'b0, 32'd0,          32'h0,         3'b000, 1, 32'h0});
        tv.push_back('{1'b1, 32'd7,          32'h1234_5678, 3'b010, 3, 32'h0});
        tv.push_back('{1'b0, 32'd7,          32'h0,         3'b000, 1, 32'h0});
        tv.push_back('{1'b1, 32'd31,         32'hDEAD_BEEF, 3'b000, 1, 32'h0});
        tv.push_back('{1'b0, 32'd31,         32'h0,         3'b000, 1, 32'hDEAD_BEEF});
        tv.push_back('{1'b0, 32'hFFFF_FFFF,  32'h0,         3'b000, 2, 32'h0});
        tv.push_back('{1'b1, 32'd300,        32'h1,         3'b111, 2, 32'h0});
        tv.push_back('{1'b1, 32'd255,        32'hA5A5_A5A5, 3'b000, 1, 32'h0});
        tv.push_back('{1'b0, 32'd255,        32'h0,         3'b000, 1, 32'hA5A5_A5A5});
        tv.push_back('{1'b1, 32'h8000_0005,  32'h0000_0099, 3'b000, 2, 32'h0});
        tv.push_back('{1'b0, 32'd5,          32'h0,         3'b000, 1, 32'h0000_0005});
        tv.push_back('{1'b0, 32'd7,          32'h0,         3'b111, 3, 32'h0});

        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({ack2, err2, rty2, dat_o2} != 35'h0) begin
            n_err++;
            $display("FAIL reset w2: ack/err/rty=%b dat=%h required all zero", {ack2, err2, rty2}, dat_o2);
        end
        n_cmp++;
        if ({ack0, err0, rty0, dat_o0} != 35'h0) begin
            n_err++;
            $display("FAIL reset w0: ack/err/rty=%b dat=%h required all zero", {ack0, err0, rty0}, dat_o0);
        end
        rst = 0;

        for (int i = 0; i < tv.size(); i++)
            xact(1'b0, tv[i].we, tv[i].adr, tv[i].dat, tv[i].cti, 0, 0, tv[i].kind, tv[i].rdat, $sformatf("vec%0d", i));

        xact(1'b0, 1'b1, 32'd9, 32'hCAFE_0009, 3'b000, 2, 0, 0, 32'h0, "abort");
        xact(1'b0, 1'b0, 32'd9, 32'h0, 3'b000, 0, 0, 1, 32'h0, "abort_rd");
        xact(1'b0, 1'b1, 32'd3, 32'hCAFE_0003, 3'b000, 0, 2, 0, 32'h0, "rst_mid");
        xact(1'b0, 1'b0, 32'd3, 32'h0, 3'b000, 0, 0, 1, 32'h0, "rst_rd");
        xact(1'b0, 1'b1, 32'd4, 32'h0000_0444, 3'b000, 0, 0, 1, 32'h0, "stb_hold");
        xact(1'b0, 1'b0, 32'd4, 32'h0, 3'b000, 0, 0, 1, 32'h0000_0444, "stb_hold_rd");

        for (int i = 0; i < 32; i++) begin
            model[i] = $urandom;
            xact(1'b1, 1'b1, 32'(i), model[i], 3'b000, 0, 0, 1, 32'h0, $sformatf("w0_wr%0d", i));
            xact(1'b1, 1'b0, 32'(i), 32'h0, 3'b000, 0, 0, 1, model[i], $sformatf("w0_rd%0d", i));
        end
        xact(1'b1, 1'b0, 32'd256, 32'h0, 3'b000, 0, 0, 2, 32'h0, "w0_err");
        xact(1'b1, 1'b1, 32'd1, 32'h0, 3'b001, 0, 0, 3, 32'h0, "w0_rty");
        xact(1'b1, 1'b0, 32'd1, 32'h0, 3'b000, 0, 0, 1, model[1], "w0_rty_rd");

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
